vproc_result_order: RTL
=======================

Name: vproc_result_order

Overview:
- In-order result scheduler between the vector unit's result producers (LSU, XREG, CSR, empty-result paths) and the XIF result port.
- Holds one result slot per XIF instruction ID and arbitrates producer writes into those slots.
- Retires results to the scalar core strictly in ID order, so producers may finish out of order.

Parameters:
XIF_ID_W, 3, width in bits of instruction IDs; slot count XIF_ID_CNT = 2**XIF_ID_W
SRC_CNT, 3, number of result producers; index 0 has highest priority
DONT_CARE_ZERO, 1'b0, drive don't-care outputs to zero instead of X

Ports:
clk_i  in  1  clock
async_rst_ni  in  1  asynchronous active-low reset
issue_valid_i  in  1  instruction with issue_id_i accepted by the vector unit; allocate its slot
issue_id_i  in  XIF_ID_W  ID to allocate
flush_i  in  1  discard all slots, restart at ID 0
src_valid_i  in  SRC_CNT  producer i offers a result
src_ready_o  out  SRC_CNT  producer i result written this cycle
src_id_i  in  SRC_CNT*XIF_ID_W  packed producer IDs; bits [i*XIF_ID_W +: XIF_ID_W]
src_we_i  in  SRC_CNT  result writes rd
src_rd_i  in  SRC_CNT*5  packed destination registers
src_data_i  in  SRC_CNT*32  packed result data
src_exc_i  in  SRC_CNT  exception flag
src_exccode_i  in  SRC_CNT*6  packed exception codes
result_valid_o  out  1  XIF result valid
result_ready_i  in  1  XIF result ready
result_id_o  out  XIF_ID_W  result ID
result_data_o  out  32  result data
result_rd_o  out  5  result rd
result_we_o  out  1  result we
result_exc_o  out  1  exception flag
result_exccode_o  out  6  exception code
head_id_o  out  XIF_ID_W  next ID to retire
pending_o  out  XIF_ID_W+1  number of non-FREE slots
protocol_err_o  out  1  one-cycle pulse on an illegal issue or write

Behaviour:
- Reset is async, active-low. All slots go to FREE, head_id_o=0, pending_o=0, result_valid_o=0, src_ready_o=0, protocol_err_o=0.
- Each slot state: FREE -> ISSUED (issue) -> DONE (producer write) -> FREE (retire). Slot payload registers (we, rd, data, exc, exccode) are not reset.
- Issue: if slot[issue_id_i] is FREE, set it ISSUED. Otherwise the issue is ignored and protocol_err_o pulses.
- Arbitration: a producer is eligible when src_valid_i[i]=1 and slot[src_id_i[i]] is ISSUED. Grant the lowest-index eligible producer only; one slot write per cycle. src_ready_o is combinational: one-hot on the granted producer, all zero if none is eligible.
- Granted write: capture the payload into the slot and set it DONE at the clock edge.
- A valid producer whose slot is FREE or DONE is never granted and raises protocol_err_o.
- Retire: result_valid_o = (slot[head] == DONE). All result_*_o outputs come straight from the head slot registers, so they stay stable while valid and not ready.
- When result_valid_o=0: result_id_o = head_id_o, and data, rd, we, exc, exccode are driven 0.
- On result_valid_o & result_ready_i: slot[head] goes FREE and head increments modulo XIF_ID_CNT (7 -> 0 for XIF_ID_W=3).
- Latency: a producer write into the head slot at edge N gives result_valid_o=1 from cycle N+1. There is no combinational producer-to-XIF bypass.
- Simultaneous events in one cycle:
  - Issue to the slot being retired that cycle: allowed; the slot ends ISSUED.
  - Issue and producer write to the same ID in the same cycle: the write is not eligible (the slot is still FREE) and protocol_err_o pulses.
  - Retire and a write to a different slot: both take effect.
- pending_o is updated with +1 per issue and -1 per retire, both applied in the same cycle when both occur. Range is 0..XIF_ID_CNT.
- flush_i (synchronous) has highest priority: all slots go FREE, head goes to 0, pending_o goes to 0. Any issue, write or retire in that cycle is dropped. src_ready_o is forced to 0 and result_valid_o to 0 during that cycle.
- An asserted reset mid-transaction drops the pending result with no handshake.

Test Plan:
- Reset, issue ID0, then SRC1 writes ID0 with data=0x1234, rd=5, we=1 -> src_ready_o=3'b010; next cycle result_valid_o=1, id=0, data=0x1234, rd=5; ready=1 -> head_id_o=1, pending_o=0.
- Issue 1,2,3; write ID3, then ID2, then ID1 -> results emitted in order 1,2,3. Before ID1 is written, result_valid_o=0 and pending_o=3.
- Issue 0,1; SRC0 (ID1) and SRC2 (ID0) both valid in the same cycle -> only SRC0 granted; SRC2 granted next cycle; retire order 0,1.
- Hold result_ready_i=0 for 4 cycles with ID0 DONE (exc=1, exccode=0x0D) -> all result outputs stable; ready=1 retires ID0.
- Issue and retire 9 instructions at XIF_ID_W=3 -> head wraps 7 -> 0; issuing ID2 while ID2 is ISSUED -> protocol_err_o pulses and the slot is unchanged.
- With 3 DONE slots, assert flush_i -> pending_o=0, head_id_o=0, result_valid_o=0 next cycle; a write to a flushed ID raises protocol_err_o.

Source files
------------

// File: rtl/vproc_result_order.sv
// In-order result scheduler: one slot per XIF instruction ID, producers fill slots
// in any order and results are handed to the scalar core strictly in ID order.
module vproc_result_order #(
  parameter int XIF_ID_W       = 3,
  parameter int SRC_CNT        = 3,
  parameter bit DONT_CARE_ZERO = 1'b0
) (
  input  logic                         clk_i,
  input  logic                         async_rst_ni,
  input  logic                         issue_valid_i,
  input  logic [XIF_ID_W-1:0]          issue_id_i,
  input  logic                         flush_i,
  input  logic [SRC_CNT-1:0]           src_valid_i,
  output logic [SRC_CNT-1:0]           src_ready_o,
  input  logic [SRC_CNT*XIF_ID_W-1:0]  src_id_i,
  input  logic [SRC_CNT-1:0]           src_we_i,
  input  logic [SRC_CNT*5-1:0]         src_rd_i,
  input  logic [SRC_CNT*32-1:0]        src_data_i,
  input  logic [SRC_CNT-1:0]           src_exc_i,
  input  logic [SRC_CNT*6-1:0]         src_exccode_i,
  output logic                         result_valid_o,
  input  logic                         result_ready_i,
  output logic [XIF_ID_W-1:0]          result_id_o,
  output logic [31:0]                  result_data_o,
  output logic [4:0]                   result_rd_o,
  output logic                         result_we_o,
  output logic                         result_exc_o,
  output logic [5:0]                   result_exccode_o,
  output logic [XIF_ID_W-1:0]          head_id_o,
  output logic [XIF_ID_W:0]            pending_o,
  output logic                         protocol_err_o
);

  localparam int XIF_ID_CNT = 1 << XIF_ID_W;

  typedef enum logic [1:0] {SLOT_FREE, SLOT_ISSUED, SLOT_DONE} slot_state_e;

  slot_state_e         state_q [XIF_ID_CNT];
  logic [31:0]         data_q  [XIF_ID_CNT];
  logic [4:0]          rd_q    [XIF_ID_CNT];
  logic                we_q    [XIF_ID_CNT];
  logic                exc_q   [XIF_ID_CNT];
  logic [5:0]          code_q  [XIF_ID_CNT];
  logic [XIF_ID_W-1:0] head_q;
  logic [XIF_ID_W:0]   pend_q;
  logic                err_q;

  logic [XIF_ID_W-1:0] sid [SRC_CNT];
  for (genvar g = 0; g < SRC_CNT; g++) begin : g_sid
    assign sid[g] = src_id_i[g*XIF_ID_W +: XIF_ID_W];
  end

  // Fixed-priority arbitration: lowest index eligible producer wins the single write port.
  logic [SRC_CNT-1:0]  grant;
  logic                gnt_any, wr_err;
  logic [XIF_ID_W-1:0] gnt_id;
  logic [31:0]         gnt_data;
  logic [4:0]          gnt_rd;
  logic                gnt_we, gnt_exc;
  logic [5:0]          gnt_code;

  always_comb begin
    grant    = '0;
    gnt_any  = 1'b0;
    wr_err   = 1'b0;
    gnt_id   = '0;
    gnt_data = '0;
    gnt_rd   = '0;
    gnt_we   = 1'b0;
    gnt_exc  = 1'b0;
    gnt_code = '0;
    for (int i = 0; i < SRC_CNT; i++) begin
      if (src_valid_i[i]) begin
        if (state_q[sid[i]] == SLOT_ISSUED) begin
          if (!gnt_any) begin
            gnt_any  = 1'b1;
            grant[i] = 1'b1;
            gnt_id   = sid[i];
            gnt_data = src_data_i[i*32 +: 32];
            gnt_rd   = src_rd_i[i*5 +: 5];
            gnt_we   = src_we_i[i];
            gnt_exc  = src_exc_i[i];
            gnt_code = src_exccode_i[i*6 +: 6];
          end
        end else begin
          wr_err = 1'b1;
        end
      end
    end
  end

  logic res_vld, retire, issue_ok, issue_err;
  assign res_vld   = (state_q[head_q] == SLOT_DONE) && !flush_i;
  assign retire    = res_vld && result_ready_i;
  // The head slot may be re-issued in the very cycle it retires.
  assign issue_ok  = issue_valid_i &&
                     ((state_q[issue_id_i] == SLOT_FREE) || (retire && issue_id_i == head_q));
  assign issue_err = issue_valid_i && !issue_ok;

  always_ff @(posedge clk_i or negedge async_rst_ni) begin
    if (!async_rst_ni) begin
      for (int i = 0; i < XIF_ID_CNT; i++) state_q[i] <= SLOT_FREE;
      head_q <= '0;
      pend_q <= '0;
      err_q  <= 1'b0;
    end else if (flush_i) begin
      for (int i = 0; i < XIF_ID_CNT; i++) state_q[i] <= SLOT_FREE;
      head_q <= '0;
      pend_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (retire)   state_q[head_q]     <= SLOT_FREE;
      if (gnt_any)  state_q[gnt_id]     <= SLOT_DONE;
      if (issue_ok) state_q[issue_id_i] <= SLOT_ISSUED;
      if (retire)   head_q <= head_q + XIF_ID_W'(1);
      pend_q <= pend_q + (XIF_ID_W+1)'(issue_ok) - (XIF_ID_W+1)'(retire);
      err_q  <= issue_err | wr_err;
    end
  end

  always_ff @(posedge clk_i) begin
    if (gnt_any && !flush_i) begin
      data_q[gnt_id] <= gnt_data;
      rd_q[gnt_id]   <= gnt_rd;
      we_q[gnt_id]   <= gnt_we;
      exc_q[gnt_id]  <= gnt_exc;
      code_q[gnt_id] <= gnt_code;
    end
  end

  always_comb begin
    result_data_o    = '0;
    result_rd_o      = '0;
    result_we_o      = 1'b0;
    result_exc_o     = 1'b0;
    result_exccode_o = '0;
    if (res_vld) begin
      result_we_o  = we_q[head_q];
      result_exc_o = exc_q[head_q];
      if (we_q[head_q] || !DONT_CARE_ZERO) begin
        result_data_o = data_q[head_q];
        result_rd_o   = rd_q[head_q];
      end
      if (exc_q[head_q] || !DONT_CARE_ZERO) result_exccode_o = code_q[head_q];
    end
  end

  assign src_ready_o    = flush_i ? '0 : grant;
  assign result_valid_o = res_vld;
  assign result_id_o    = head_q;
  assign head_id_o      = head_q;
  assign pending_o      = pend_q;
  assign protocol_err_o = err_q;

endmodule
